// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream bundle carrying LANES parallel streams sharing one clock.
// The upstream side of the arbiter uses LANES = NUM_PORTS, and the
// downstream side uses LANES = 1.
// Optional macro AXIS_ARB_TDEST_EN adds a tdest field of DEST_WIDTH bits.
interface axis_packet_arbiter_if #(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 32
`ifdef AXIS_ARB_TDEST_EN
    ,
    parameter int DEST_WIDTH = 1
`endif
);
    logic [LANES*DATA_WIDTH-1:0] tdata;
    logic [LANES-1:0]            tlast;
    logic [LANES-1:0]            tvalid;
    logic [LANES-1:0]            tready;
`ifdef AXIS_ARB_TDEST_EN
    logic [DEST_WIDTH-1:0]       tdest;
`endif

    modport master (
`ifdef AXIS_ARB_TDEST_EN
        output tdest,
`endif
        output tdata, tlast, tvalid,
        input  tready
    );

    modport slave (
`ifdef AXIS_ARB_TDEST_EN
        input  tdest,
`endif
        input  tdata, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter: merges NUM_PORTS AXI-Stream inputs onto
// one registered AXI-Stream output.
// - A grant is held until the granted input's tlast beat is accepted, so
//   packets never interleave.
// - Optional macro AXIS_ARB_TDEST_EN adds dn_axis.tdest, which carries the
//   index of the source input for each beat.
module axis_packet_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_packet_arbiter_if.slave  up_axis,
    axis_packet_arbiter_if.master dn_axis,
    output logic                  busy
);
    localparam int GW = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_PORTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [GW-1:0]         r_gnt;
    logic [GW-1:0]         w_gnt_nxt;
    logic [GW-1:0]         r_last;
    logic [GW-1:0]         w_last_nxt;
    logic [GW-1:0]         w_pick;
    logic                  w_any;
    logic                  w_out_free;
    logic                  w_accept;
    logic                  w_beat_last;
    logic [DATA_WIDTH-1:0] w_beat_data;
    logic [NUM_PORTS-1:0]  w_up_tready;

    logic                  r_dn_tvalid;
    logic                  r_dn_tlast;
    logic [DATA_WIDTH-1:0] r_dn_tdata;
`ifdef AXIS_ARB_TDEST_EN
    logic [GW-1:0]         r_dn_tdest;
`endif

    // Round-robin search starting just after the last winner, with explicit wrap.
    always_comb begin
        int v_idx;
        v_idx  = 0;
        w_pick = r_last;
        w_any  = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            v_idx = int'(r_last) + k;
            if (v_idx >= NUM_PORTS) begin
                v_idx = v_idx - NUM_PORTS;
            end else begin
                v_idx = v_idx;
            end
            if (!w_any && up_axis.tvalid[v_idx]) begin
                w_any  = 1'b1;
                w_pick = GW'(v_idx);
            end else begin
                w_any  = w_any;
            end
        end
    end

    // Select the granted input's beat and decide whether it is accepted this cycle.
    always_comb begin
        w_beat_data = up_axis.tdata[r_gnt*DATA_WIDTH +: DATA_WIDTH];
        w_beat_last = up_axis.tlast[r_gnt];
        w_out_free  = !r_dn_tvalid || dn_axis.tready[0];
        w_up_tready = '0;
        if (r_state == ST_GRANT) begin
            w_up_tready[r_gnt] = w_out_free;
        end else begin
            w_up_tready = '0;
        end
        w_accept = (r_state == ST_GRANT) && up_axis.tvalid[r_gnt] && w_out_free;
    end

    // Next-state logic: pick a winner in IDLE, release the lock on an accepted tlast.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_pick;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (w_accept && w_beat_last) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_gnt;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers; the pointer restarts so input 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_last  <= LAST_INIT;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Output register: load on accept, drain on downstream ready, hold under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dn_tvalid <= 1'b0;
            r_dn_tlast  <= 1'b0;
            r_dn_tdata  <= '0;
`ifdef AXIS_ARB_TDEST_EN
            r_dn_tdest  <= '0;
`endif
        end else if (w_accept) begin
            r_dn_tvalid <= 1'b1;
            r_dn_tlast  <= w_beat_last;
            r_dn_tdata  <= w_beat_data;
`ifdef AXIS_ARB_TDEST_EN
            r_dn_tdest  <= r_gnt;
`endif
        end else if (dn_axis.tready[0]) begin
            r_dn_tvalid <= 1'b0;
        end else begin
            r_dn_tvalid <= r_dn_tvalid;
        end
    end

    assign up_axis.tready = w_up_tready;
    assign dn_axis.tvalid = r_dn_tvalid;
    assign dn_axis.tlast  = r_dn_tlast;
    assign dn_axis.tdata  = r_dn_tdata;
`ifdef AXIS_ARB_TDEST_EN
    assign dn_axis.tdest  = r_dn_tdest;
`endif
    assign busy = (r_state == ST_GRANT);
endmodule
